centroid_calc: RTL
==================

CENTROID_CALC -- requirements
Module: centroid_calc

Interface
REQ-001 SHALL have parameter COOR_W, default 10, giving the output coordinate width.
REQ-002 SHALL have parameter DIV_CYC, default 32, giving the divider iterations, equal to the numerator width.
REQ-003 SHALL have port sclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port s_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port vsync_i, input, 1 bit: frame-valid; high during the active frame.
REQ-006 SHALL have port x_coor, input, 32 bits: running column sum of target pixels; forced to 0 while vsync_i is low.
REQ-007 SHALL have port y_coor, input, 32 bits: running row sum of target pixels; forced to 0 while vsync_i is low.
REQ-008 SHALL have port valid_num, input, 16 bits: running target-pixel count; forced to 0 while vsync_i is low.
REQ-009 SHALL have port coor_valid_flag, input, 1 bit: the count threshold has been reached this frame.
REQ-010 SHALL have port cx_o, output, COOR_W bits: centroid column.
REQ-011 SHALL have port cy_o, output, COOR_W bits: centroid row.
REQ-012 SHALL have port found_o, output, 1 bit: the last completed frame contained a valid target.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle pulse marking new result registers.
REQ-014 SHALL have port busy_o, output, 1 bit: high while the divider runs.
REQ-015 SHALL have port overrun_o, output, 1 bit: sticky flag; a frame end arrived while busy.

Function
REQ-016 SHALL register vsync_i into vsync_r1 and define frame end E as the cycle where vsync_r1=1 and vsync_i=0.
REQ-017 SHALL copy x_coor, y_coor, valid_num and coor_valid_flag into shadow registers every cycle vsync_i=1, and hold the shadows while vsync_i=0.
REQ-018 SHALL implement FSM states IDLE, DIV and DONE.
REQ-019 SHALL, in IDLE at E, take one of two paths:
- shadow flag=1 and shadow count!=0: load both dividers from the shadows and go to DIV.
- otherwise: go directly to DONE with found pending = 0.
REQ-020 SHALL use two parallel restoring dividers (x and y).
- Each produces one quotient bit per cycle, MSB first.
- Each has a 32-bit numerator, a 16-bit divisor and a 17-bit partial remainder.
REQ-021 SHALL stay in DIV for exactly DIV_CYC cycles, counted by a 6-bit iteration counter, then go to DONE.
REQ-022 SHALL truncate quotients (floor); the remainder is discarded.
REQ-023 SHALL saturate each 32-bit quotient greater than 2^COOR_W-1 to 2^COOR_W-1 before output.
REQ-024 SHALL, in DONE, do the following for one cycle and then return to IDLE:
- register cx_o, cy_o and found_o=1 when the divider path was taken;
- otherwise set found_o=0 and hold cx_o and cy_o;
- pulse done_o.
REQ-025 SHALL place done_o in the cycle DIV_CYC+1 clocks after E on the divider path, and 1 clock after E on the skip path.
REQ-026 SHALL hold busy_o high in DIV and DONE and low in IDLE.
REQ-027 SHALL ignore an E that occurs while not in IDLE, and set overrun_o at that event.
REQ-028 SHALL never let shadow updates alter the values already loaded into the dividers.
REQ-029 SHALL hold outputs stable between done_o pulses.
REQ-030 SHALL raise no E and start no FSM activity when vsync_i is low from reset onward.

Reset
REQ-031 SHALL, with s_rst=1 at a clock edge, clear the following and return the FSM to IDLE from any state, including mid-DIV:
- cx_o, cy_o, found_o, done_o, busy_o and overrun_o;
- the shadows, vsync_r1, the dividers and the iteration counter.
REQ-032 SHALL lose any division aborted by reset, with no done_o pulse produced for it.

Verification
REQ-033 SHALL cover the nominal frame: vsync high with x=3200, y=2400, n=20, flag=1, then vsync falls -> done_o at E+33 with cx=160, cy=120, found=1.
REQ-034 SHALL cover truncation: x=1000, y=999, n=3, flag=1 -> cx=333, cy=333, found=1.
REQ-035 SHALL cover the no-target frame: n=0, or flag=0 with n=500 -> done_o at E+1, found=0, cx and cy unchanged.
REQ-036 SHALL cover saturation: x=0xFFFFFFFF, y=100, n=1, flag=1 -> cx=1023, cy=100.
REQ-037 SHALL cover overrun: a second vsync fall 10 cycles after the first -> overrun_o=1, and the first result is completed unaffected.
REQ-038 SHALL cover reset mid-operation: s_rst asserted at E+15 -> all outputs 0 on the next edge, FSM in IDLE, no done_o.

Source files
------------

// File: rtl/centroid_calc.sv
// Frame centroid: at each frame end, divides the accumulated column/row sums by the
// pixel count with two bit-serial restoring dividers and publishes saturated coordinates.
module centroid_calc #(
    parameter int COOR_W  = 10,
    parameter int DIV_CYC = 32
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              vsync_i,
    input  logic [31:0]       x_coor,
    input  logic [31:0]       y_coor,
    input  logic [15:0]       valid_num,
    input  logic              coor_valid_flag,
    output logic [COOR_W-1:0] cx_o,
    output logic [COOR_W-1:0] cy_o,
    output logic              found_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [5:0] LAST_IT = 6'(DIV_CYC - 1);

    // One restoring step; the numerator register doubles as the quotient register,
    // so after DIV_CYC steps it holds the full quotient.  Returns {rem, num}.
    function automatic logic [48:0] div_step(input logic [31:0] num,
                                             input logic [16:0] rem,
                                             input logic [15:0] den);
        logic [16:0] trial;
        trial = {rem[15:0], num[31]};
        if (trial >= {1'b0, den})
            div_step = {trial - {1'b0, den}, num[30:0], 1'b1};
        else
            div_step = {trial, num[30:0], 1'b0};
    endfunction

    function automatic logic [COOR_W-1:0] sat(input logic [31:0] q);
        if (|q[31:COOR_W])
            sat = {COOR_W{1'b1}};
        else
            sat = q[COOR_W-1:0];
    endfunction

    logic              vsync_r1_q;
    logic [31:0]       sx_q, sy_q;
    logic [15:0]       sn_q;
    logic              sf_q;
    logic [1:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [31:0]       xnum_q, xnum_d, ynum_q, ynum_d;
    logic [16:0]       xrem_q, xrem_d, yrem_q, yrem_d;
    logic [15:0]       den_q, den_d;
    logic [COOR_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic              found_q, found_d, done_q, done_d, ovr_q, ovr_d;
    logic [48:0]       xstep, ystep;
    logic              frame_end;

    always_comb begin
        frame_end = vsync_r1_q & ~vsync_i;
        xstep     = div_step(xnum_q, xrem_q, den_q);
        ystep     = div_step(ynum_q, yrem_q, den_q);
        state_d   = state_q;
        cnt_d     = cnt_q;
        xnum_d    = xnum_q;
        ynum_d    = ynum_q;
        xrem_d    = xrem_q;
        yrem_d    = yrem_q;
        den_d     = den_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        found_d   = found_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q | (frame_end & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (frame_end) begin
                    if (sf_q && (sn_q != 16'd0)) begin
                        xnum_d  = sx_q;
                        ynum_d  = sy_q;
                        xrem_d  = 17'd0;
                        yrem_d  = 17'd0;
                        den_d   = sn_q;
                        cnt_d   = 6'd0;
                        state_d = DIV;
                    end else begin
                        found_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DIV: begin
                {xrem_d, xnum_d} = xstep;
                {yrem_d, ynum_d} = ystep;
                cnt_d = cnt_q + 6'd1;
                // Results are captured on the final step so they appear with done_o.
                if (cnt_q == LAST_IT) begin
                    cx_d    = sat(xstep[31:0]);
                    cy_d    = sat(ystep[31:0]);
                    found_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            vsync_r1_q <= 1'b0;
            sx_q       <= '0;
            sy_q       <= '0;
            sn_q       <= '0;
            sf_q       <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            xnum_q     <= '0;
            ynum_q     <= '0;
            xrem_q     <= '0;
            yrem_q     <= '0;
            den_q      <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            found_q    <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            vsync_r1_q <= vsync_i;
            if (vsync_i) begin
                sx_q <= x_coor;
                sy_q <= y_coor;
                sn_q <= valid_num;
                sf_q <= coor_valid_flag;
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xnum_q  <= xnum_d;
            ynum_q  <= ynum_d;
            xrem_q  <= xrem_d;
            yrem_q  <= yrem_d;
            den_q   <= den_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            found_q <= found_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cx_o      = cx_q;
    assign cy_o      = cy_q;
    assign found_o   = found_q;
    assign done_o    = done_q;
    assign busy_o    = (state_q != IDLE);
    assign overrun_o = ovr_q;

endmodule
